// File: rtl/ee2026_ui_pkg.sv
// Shared UI definitions: pushbutton channel FSM encodings, board button indices
// and a counter-width helper used by the input conditioner.
package ee2026_ui_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM_P = 3'd1;
  localparam logic [2:0] ST_HELD  = 3'd2;
  localparam logic [2:0] ST_LONG  = 3'd3;
  localparam logic [2:0] ST_ARM_R = 3'd4;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  // Bits needed to hold 0..max_val without wrapping (never narrower than 1).
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One pushbutton channel: 2-FF synchroniser, debounce/hold FSM with saturating
// counters, and registered level / press / release / long-press outputs.
module pb_channel
  import ee2026_ui_pkg::*;
#(
  parameter int DEBOUNCE_T = 20,
  parameter int LONG_T     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic tick,
  output logic level,
  output logic press_evt,
  output logic release_evt,
  output logic long_evt
);

  localparam int DW = cnt_width(DEBOUNCE_T);
  localparam int HW = cnt_width(LONG_T);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_T);
  localparam logic [HW-1:0] H_MAX = HW'(LONG_T);

  logic          sync1_r;
  logic          sync2_r;
  logic [2:0]    state_r;
  logic [2:0]    state_nx_s;
  logic [DW-1:0] dcnt_r;
  logic [DW-1:0] dcnt_nx_s;
  logic [DW-1:0] dcnt_inc_s;
  logic [HW-1:0] hcnt_r;
  logic [HW-1:0] hcnt_nx_s;
  logic [HW-1:0] hcnt_tick_s;
  logic          long_flag_r;
  logic          long_flag_nx_s;
  logic          level_r;
  logic          level_nx_s;
  logic          press_r;
  logic          press_nx_s;
  logic          release_r;
  logic          release_nx_s;
  logic          long_r;
  logic          long_nx_s;

  // Saturating counter increments; hcnt advances only on the shared tick.
  always_comb begin
    dcnt_inc_s  = (dcnt_r == D_MAX) ? D_MAX : dcnt_r + DW'(1);
    hcnt_tick_s = (tick && (hcnt_r != H_MAX)) ? hcnt_r + HW'(1) : hcnt_r;
  end

  // Next-state and next-output logic for the channel FSM.
  always_comb begin
    state_nx_s     = state_r;
    dcnt_nx_s      = dcnt_r;
    hcnt_nx_s      = hcnt_r;
    long_flag_nx_s = long_flag_r;
    level_nx_s     = level_r;
    press_nx_s     = 1'b0;
    release_nx_s   = 1'b0;
    long_nx_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sync2_r) begin
          state_nx_s = ST_ARM_P;
          dcnt_nx_s  = {DW{1'b0}};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ARM_P: begin
        if (!sync2_r) begin
          state_nx_s = ST_IDLE;
        end else if (tick) begin
          dcnt_nx_s = dcnt_inc_s;
          if (dcnt_inc_s == D_MAX) begin
            state_nx_s     = ST_HELD;
            hcnt_nx_s      = {HW{1'b0}};
            long_flag_nx_s = 1'b0;
            level_nx_s     = 1'b1;
            press_nx_s     = 1'b1;
          end else begin
            state_nx_s = ST_ARM_P;
          end
        end else begin
          state_nx_s = ST_ARM_P;
        end
      end
      ST_HELD: begin
        hcnt_nx_s = hcnt_tick_s;
        if (!sync2_r) begin
          state_nx_s = ST_ARM_R;
          dcnt_nx_s  = {DW{1'b0}};
        end else if (hcnt_tick_s == H_MAX) begin
          state_nx_s     = ST_LONG;
          long_flag_nx_s = 1'b1;
          long_nx_s      = 1'b1;
        end else begin
          state_nx_s = ST_HELD;
        end
      end
      ST_LONG: begin
        hcnt_nx_s = hcnt_tick_s;
        if (!sync2_r) begin
          state_nx_s = ST_ARM_R;
          dcnt_nx_s  = {DW{1'b0}};
        end else begin
          state_nx_s = ST_LONG;
        end
      end
      ST_ARM_R: begin
        // hcnt keeps running here so a release bounce never restarts the long-press timer.
        hcnt_nx_s = hcnt_tick_s;
        if (sync2_r) begin
          state_nx_s = long_flag_r ? ST_LONG : ST_HELD;
        end else if (tick) begin
          dcnt_nx_s = dcnt_inc_s;
          if (dcnt_inc_s == D_MAX) begin
            state_nx_s   = ST_IDLE;
            level_nx_s   = 1'b0;
            release_nx_s = 1'b1;
          end else begin
            state_nx_s = ST_ARM_R;
          end
        end else begin
          state_nx_s = ST_ARM_R;
        end
      end
      default: begin
        state_nx_s     = ST_IDLE;
        dcnt_nx_s      = {DW{1'b0}};
        hcnt_nx_s      = {HW{1'b0}};
        long_flag_nx_s = 1'b0;
        level_nx_s     = 1'b0;
      end
    endcase
  end

  // Synchroniser, FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      state_r     <= ST_IDLE;
      dcnt_r      <= {DW{1'b0}};
      hcnt_r      <= {HW{1'b0}};
      long_flag_r <= 1'b0;
      level_r     <= 1'b0;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
      long_r      <= 1'b0;
    end else begin
      sync1_r     <= btn_raw;
      sync2_r     <= sync1_r;
      state_r     <= state_nx_s;
      dcnt_r      <= dcnt_nx_s;
      hcnt_r      <= hcnt_nx_s;
      long_flag_r <= long_flag_nx_s;
      level_r     <= level_nx_s;
      press_r     <= press_nx_s;
      release_r   <= release_nx_s;
      long_r      <= long_nx_s;
    end
  end

  assign level       = level_r;
  assign press_evt   = press_r;
  assign release_evt = release_r;
  assign long_evt    = long_r;

endmodule

// File: rtl/pb_input_conditioner.sv
// Board pushbutton conditioner: shared timebase tick plus one independent
// debounce/event channel per button.
module pb_input_conditioner
  import ee2026_ui_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int N_BTN      = 5,
  parameter int DEBOUNCE_T = 20,
  parameter int LONG_T     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             tick
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TW       = cnt_width(TICK_DIV - 1);
  localparam logic [TW-1:0] T_TERM = TW'(TICK_DIV - 1);

  logic [TW-1:0] tcnt_r;
  logic [TW-1:0] tcnt_nx_s;
  logic          tick_r;

  // Tick counter wraps at the terminal value.
  always_comb begin
    if (tcnt_r == T_TERM) begin
      tcnt_nx_s = {TW{1'b0}};
    end else begin
      tcnt_nx_s = tcnt_r + TW'(1);
    end
  end

  // tick_r is loaded from the next count so it is high exactly while tcnt_r sits at terminal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_r <= {TW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      tcnt_r <= tcnt_nx_s;
      tick_r <= (tcnt_nx_s == T_TERM);
    end
  end

  assign tick = tick_r;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    pb_channel #(
      .DEBOUNCE_T(DEBOUNCE_T),
      .LONG_T    (LONG_T)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .tick       (tick_r),
      .level      (btn_level[i]),
      .press_evt  (btn_press[i]),
      .release_evt(btn_release[i]),
      .long_evt   (btn_long[i])
    );
  end

endmodule

// File: tb/tb_pb_input_conditioner.sv
// Directed bench for pb_input_conditioner with a 10-clk tick, DEBOUNCE_T=3, LONG_T=8;
// event cycles are hand-computed relative to reset release.
module tb_pb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_raw = 5'b00000;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;
  logic [4:0] btn_long;
  logic       tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int press_n[5];
  int press_at[5];
  int rel_n[5];
  int rel_at[5];
  int long_n[5];
  int long_at[5];
  int tick_n;
  int tick_first;

  always #5 clk = ~clk;

  pb_input_conditioner #(
    .CLK_HZ    (1000),
    .TICK_HZ   (100),
    .N_BTN     (5),
    .DEBOUNCE_T(3),
    .LONG_T    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .tick       (tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    for (int ch = 0; ch < 5; ch++) begin
      press_n[ch]  = 0;
      press_at[ch] = -1;
      rel_n[ch]    = 0;
      rel_at[ch]   = -1;
      long_n[ch]   = 0;
      long_at[ch]  = -1;
    end
    tick_n     = 0;
    tick_first = -1;
  endtask

  // One clock: sample #1 after the edge and log every pulse with its cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int ch = 0; ch < 5; ch++) begin
      if (btn_press[ch]) begin
        press_n[ch]++;
        press_at[ch] = cyc;
      end
      if (btn_release[ch]) begin
        rel_n[ch]++;
        rel_at[ch] = cyc;
      end
      if (btn_long[ch]) begin
        long_n[ch]++;
        long_at[ch] = cyc;
      end
    end
    if (tick) begin
      tick_n++;
      if (tick_first < 0) tick_first = cyc;
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    clear_log();
  endtask

  initial begin
    clear_log();

    // 1: reset with all buttons held, then press/long/release on all channels
    btn_raw = 5'b11111;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outputs", {11'd0, btn_level, btn_press, btn_release, btn_long, tick}, 32'd0);
    rst = 1'b0;
    cyc = 0;
    clear_log();
    run_to(29);
    check_eq("t1_level_pre", btn_level, 32'd0);
    run_to(30);
    check_eq("t1_level_at_press", btn_level, 32'h1f);
    run_to(120);
    for (int ch = 0; ch < 5; ch++) begin
      check_eq($sformatf("t1_press_at_%0d", ch), press_at[ch], 32'd30);
      check_eq($sformatf("t1_press_n_%0d", ch), press_n[ch], 32'd1);
      check_eq($sformatf("t1_long_at_%0d", ch), long_at[ch], 32'd110);
    end
    btn_raw = 5'b00000;
    run_to(160);
    for (int ch = 0; ch < 5; ch++) begin
      check_eq($sformatf("t1_rel_at_%0d", ch), rel_at[ch], 32'd150);
      check_eq($sformatf("t1_long_n_%0d", ch), long_n[ch], 32'd1);
    end
    check_eq("t1_level_end", btn_level, 32'd0);
    check_eq("t1_tick_first", tick_first, 32'd9);
    check_eq("t1_tick_n", tick_n, 32'd16);

    // 2: clean long press on ch1
    do_reset();
    run_to(5);
    btn_raw = 5'b00010;
    run_to(100);
    check_eq("t2_level_mid", btn_level, 32'h02);
    run_to(205);
    btn_raw = 5'b00000;
    run_to(240);
    check_eq("t2_press_at", press_at[1], 32'd30);
    check_eq("t2_press_n", press_n[1], 32'd1);
    check_eq("t2_long_at", long_at[1], 32'd110);
    check_eq("t2_long_n", long_n[1], 32'd1);
    check_eq("t2_rel_at", rel_at[1], 32'd230);
    check_eq("t2_rel_n", rel_n[1], 32'd1);
    check_eq("t2_others", press_n[0] + press_n[2] + press_n[3] + press_n[4], 32'd0);

    // 3: 15-clk glitch on ch0 is dropped
    do_reset();
    run_to(5);
    btn_raw = 5'b00001;
    run_to(20);
    btn_raw = 5'b00000;
    run_to(60);
    check_eq("t3_events", press_n[0] + rel_n[0] + long_n[0], 32'd0);
    check_eq("t3_level", btn_level, 32'd0);

    // 4: release bounce on ch3: low 12, high 5, low
    do_reset();
    run_to(5);
    btn_raw = 5'b01000;
    run_to(60);
    btn_raw = 5'b00000;
    run_to(72);
    btn_raw = 5'b01000;
    run_to(77);
    btn_raw = 5'b00000;
    run_to(100);
    check_eq("t4_level_arm_r", btn_level, 32'h08);
    run_to(130);
    check_eq("t4_press_n", press_n[3], 32'd1);
    check_eq("t4_press_at", press_at[3], 32'd30);
    check_eq("t4_rel_n", rel_n[3], 32'd1);
    check_eq("t4_rel_at", rel_at[3], 32'd110);
    check_eq("t4_long_n", long_n[3], 32'd0);
    check_eq("t4_level_end", btn_level, 32'd0);

    // 5: short press on ch4
    do_reset();
    run_to(5);
    btn_raw = 5'b10000;
    run_to(65);
    btn_raw = 5'b00000;
    run_to(100);
    check_eq("t5_press_at", press_at[4], 32'd30);
    check_eq("t5_rel_at", rel_at[4], 32'd90);
    check_eq("t5_long_n", long_n[4], 32'd0);

    // 6: simultaneous ch0/ch2 press, then reset while held
    do_reset();
    run_to(5);
    btn_raw = 5'b00101;
    run_to(50);
    check_eq("t6_press_at_0", press_at[0], 32'd30);
    check_eq("t6_press_at_2", press_at[2], 32'd30);
    check_eq("t6_press_n", press_n[0] + press_n[2], 32'd2);
    check_eq("t6_level_held", btn_level, 32'h05);
    rst = 1'b1;
    #1;
    check_eq("t6_level_rst", btn_level, 32'd0);
    run_to(60);
    btn_raw = 5'b00000;
    rst = 1'b0;
    run_to(100);
    check_eq("t6_no_release", rel_n[0] + rel_n[2], 32'd0);
    check_eq("t6_level_end", btn_level, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
